// File: rtl/nibble_array_collector_if.sv
// Handshake bundle for nibble_array_collector: element input side and packed-word output side.
interface nibble_array_collector_if #(
  parameter int unsigned ELEM_W    = 4,
  parameter int unsigned NUM_ELEMS = 5
);
  logic                                in_valid;
  logic                                in_ready;
  logic [ELEM_W-1:0]                   in_data;
  logic                                in_last;
  logic                                flush;
  logic                                out_valid;
  logic                                out_ready;
  logic [ELEM_W*NUM_ELEMS-1:0]         out_data;
  logic [$clog2(NUM_ELEMS+1)-1:0]      out_count;

  modport master (
    output in_valid, in_data, in_last, flush, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, flush, out_ready,
    output in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/nibble_array_collector.sv
// Gathers serial elements into a fill buffer and presents them as one packed word,
// first element at the MSBs; short words (in_last) are zero-padded.
module nibble_array_collector #(
  parameter int unsigned ELEM_W    = 4,
  parameter int unsigned NUM_ELEMS = 5
) (
  input logic                      clk,
  input logic                      rst_n,
  nibble_array_collector_if.slave  bus
);
  localparam int unsigned OUT_W = ELEM_W * NUM_ELEMS;
  localparam int unsigned IDX_W = $clog2(NUM_ELEMS);
  localparam int unsigned CNT_W = $clog2(NUM_ELEMS + 1);
  localparam logic [IDX_W-1:0] IdxMax = IDX_W'(NUM_ELEMS - 1);

  typedef enum logic [0:0] {StFill, StFull} state_e;

  state_e             st_q, st_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ELEM_W-1:0]  arr_q [NUM_ELEMS];
  logic [ELEM_W-1:0]  arr_d [NUM_ELEMS];
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               ready_q;
  logic [OUT_W-1:0]   word_d;
  logic               in_ready;
  logic               accept;

  // ready_q holds in_ready low until the first edge after reset release
  assign in_ready      = ready_q & ~bus.flush & ((st_q == StFill) | bus.out_ready);
  assign accept        = bus.in_valid & in_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (st_q == StFull);
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;

  // Word that would be presented if the current element closes it
  always_comb begin
    word_d = '0;
    for (int unsigned i = 0; i < NUM_ELEMS; i++) begin
      if (IDX_W'(i) < idx_q) begin
        word_d[OUT_W-1-i*ELEM_W -: ELEM_W] = arr_q[i];
      end else if (IDX_W'(i) == idx_q) begin
        word_d[OUT_W-1-i*ELEM_W -: ELEM_W] = bus.in_data;
      end
    end
  end

  always_comb begin
    st_d        = st_q;
    idx_d       = idx_q;
    arr_d       = arr_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    unique case (st_q)
      StFill: begin
        if (bus.flush) begin
          idx_d = '0;
          for (int unsigned i = 0; i < NUM_ELEMS; i++) arr_d[i] = '0;
        end else if (accept) begin
          if (idx_q == IdxMax || bus.in_last) begin
            out_data_d  = word_d;
            out_count_d = CNT_W'(idx_q) + CNT_W'(1);
            idx_d       = '0;
            for (int unsigned i = 0; i < NUM_ELEMS; i++) arr_d[i] = '0;
            st_d        = StFull;
          end else begin
            arr_d[idx_q] = bus.in_data;
            idx_d        = idx_q + IDX_W'(1);
          end
        end
      end
      StFull: begin
        if (bus.flush) begin
          idx_d = '0;
          for (int unsigned i = 0; i < NUM_ELEMS; i++) arr_d[i] = '0;
        end
        if (bus.out_ready) begin
          out_data_d  = '0;
          out_count_d = '0;
          st_d        = StFill;
          // idx_q is 0 in this state, so word_d is {in_data, zeros}
          if (accept) begin
            if (bus.in_last) begin
              out_data_d  = word_d;
              out_count_d = CNT_W'(1);
              st_d        = StFull;
            end else begin
              arr_d[0] = bus.in_data;
              idx_d    = IDX_W'(1);
            end
          end
        end
      end
      default: st_d = StFill;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= StFill;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
      ready_q     <= 1'b0;
      for (int unsigned i = 0; i < NUM_ELEMS; i++) arr_q[i] <= '0;
    end else begin
      st_q        <= st_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      ready_q     <= 1'b1;
      for (int unsigned i = 0; i < NUM_ELEMS; i++) arr_q[i] <= arr_d[i];
    end
  end
endmodule
